// File: rtl/cache_rd_arbiter.sv
// -----------------------------------------------------------------------------
// cache_rd_arbiter
//
// Purpose:
//   Shares one AXI read address/data channel pair between the instruction-cache
//   and data-cache refill interfaces. One AR request is granted at a time. The
//   data cache has priority, and a starvation counter hands the next contested
//   grant to the instruction cache after STARVE_MAX consecutive data-cache wins.
//   Each request carries a per-source ARID, and R beats are steered back to
//   the owning cache by RID. A data-cache read to a line with a pending write
//   is held off until the write drains.
//
// Ports:
//   aclk, areset                  clock, asynchronous active-high reset
//   icache_rd_* / dcache_rd_*     cache read request (req/type/addr in, rdy out)
//   icache_ret_* / dcache_ret_*   returned beats (valid/last/data out)
//   wr_pending, wr_pending_addr   data-cache write buffer status
//   ar* / arvalid / arready       AXI read address channel (master side)
//   rid/rdata/rlast/rvalid/rready AXI read data channel (master side)
//   rd_err                        sticky flag: R beat with unknown/idle RID
// -----------------------------------------------------------------------------
module cache_rd_arbiter #(
  parameter logic [3:0]  ICACHE_ID  = 4'd0,
  parameter logic [3:0]  DCACHE_ID  = 4'd1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        aclk,
  input  logic        areset,

  input  logic        icache_rd_req,
  input  logic [2:0]  icache_rd_type,
  input  logic [31:0] icache_rd_addr,
  output logic        icache_rd_rdy,
  output logic        icache_ret_valid,
  output logic        icache_ret_last,
  output logic [31:0] icache_ret_data,

  input  logic        dcache_rd_req,
  input  logic [2:0]  dcache_rd_type,
  input  logic [31:0] dcache_rd_addr,
  output logic        dcache_rd_rdy,
  output logic        dcache_ret_valid,
  output logic        dcache_ret_last,
  output logic [31:0] dcache_ret_data,

  input  logic        wr_pending,
  input  logic [31:0] wr_pending_addr,

  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,

  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,

  output logic        rd_err
);

  localparam int unsigned CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  typedef enum logic {
    S_IDLE,
    S_SEND
  } state_t;

  state_t        state;
  logic          busy_i;
  logic          busy_d;
  logic          ar_src_d;
  logic [CW-1:0] starve_cnt;

  logic          hazard;
  logic          elig_i;
  logic          elig_d;
  logic          pick_i;
  logic          pick_d;
  logic          grant_i;
  logic          grant_d;
  logic [2:0]    sel_type;
  logic [31:0]   sel_addr;
  logic          sel_line;
  logic          hit_i;
  logic          hit_d;
  logic          stray;

  // Only the line index matters for the write hazard, so the low nibble of the
  // pending-write address is intentionally ignored.
  logic          unused_wr_low;
  assign unused_wr_low = ^wr_pending_addr[3:0];

  assign hazard = wr_pending && (dcache_rd_addr[31:4] == wr_pending_addr[31:4]);
  assign elig_i = icache_rd_req && !busy_i;
  assign elig_d = dcache_rd_req && !busy_d && !hazard;

  // The data cache wins a contested cycle unless the icache has already lost
  // STARVE_MAX times in a row; an uncontested eligible requester always wins.
  assign pick_i  = elig_i && (!elig_d || (starve_cnt == STARVE_LIM));
  assign pick_d  = elig_d && !pick_i;
  assign grant_i = (state == S_IDLE) && pick_i;
  assign grant_d = (state == S_IDLE) && pick_d;

  // The reset term is kept out of the grant path that feeds the flops and is
  // applied only on the outputs, so nothing is offered while reset is held.
  assign icache_rd_rdy = grant_i && !areset;
  assign dcache_rd_rdy = grant_d && !areset;
  assign rready        = !areset;
  assign arburst       = 2'b01;

  // AR fields for whichever source is granted this cycle.
  assign sel_type = grant_d ? dcache_rd_type : icache_rd_type;
  assign sel_addr = grant_d ? dcache_rd_addr : icache_rd_addr;
  assign sel_line = (sel_type == 3'b100);

  // R beats are forwarded only to a source that actually has a read in
  // flight; anything else is dropped and flagged.
  assign hit_i = rvalid && (rid == ICACHE_ID) && busy_i;
  assign hit_d = rvalid && (rid == DCACHE_ID) && busy_d;
  assign stray = rvalid && !hit_i && !hit_d;

  assign icache_ret_valid = hit_i;
  assign icache_ret_last  = hit_i && rlast;
  assign icache_ret_data  = hit_i ? rdata : 32'd0;
  assign dcache_ret_valid = hit_d;
  assign dcache_ret_last  = hit_d && rlast;
  assign dcache_ret_data  = hit_d ? rdata : 32'd0;

  // AR-side state machine. A grant latches the request into the AR registers
  // and moves to SEND; the fields are then frozen until arready, so the slave
  // sees a stable request for as long as it stalls.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state    <= S_IDLE;
      arvalid  <= 1'b0;
      arid     <= 4'd0;
      araddr   <= 32'd0;
      arlen    <= 8'd0;
      arsize   <= 3'd0;
      ar_src_d <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_i || grant_d) begin
            state    <= S_SEND;
            arvalid  <= 1'b1;
            ar_src_d <= grant_d;
            arid     <= grant_d ? DCACHE_ID : ICACHE_ID;
            araddr   <= sel_line ? {sel_addr[31:4], 4'b0000} : sel_addr;
            arlen    <= sel_line ? 8'd3 : 8'd0;
            arsize   <= sel_line ? 3'd2 : {1'b0, sel_type[1:0]};
          end
        end
        S_SEND: begin
          if (arready) begin
            state   <= S_IDLE;
            arvalid <= 1'b0;
          end
        end
        default: begin
          state   <= S_IDLE;
          arvalid <= 1'b0;
        end
      endcase
    end
  end

  // Per-source outstanding flags. A source becomes busy when its AR handshake
  // completes and is freed by its last R beat. Both events may happen in the
  // same cycle for different sources and are applied independently.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      busy_i <= 1'b0;
      busy_d <= 1'b0;
    end else begin
      if (hit_i && rlast) begin
        busy_i <= 1'b0;
      end
      if (hit_d && rlast) begin
        busy_d <= 1'b0;
      end
      if (arvalid && arready) begin
        if (ar_src_d) begin
          busy_d <= 1'b1;
        end else begin
          busy_i <= 1'b1;
        end
      end
    end
  end

  // Starvation counter: counts dcache grants taken while the icache was
  // asking, saturating at the limit. Any icache grant, or a dcache grant with
  // no icache demand, starts the count over.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      starve_cnt <= '0;
    end else if (grant_i) begin
      starve_cnt <= '0;
    end else if (grant_d) begin
      if (!icache_rd_req) begin
        starve_cnt <= '0;
      end else if (starve_cnt != STARVE_LIM) begin
        starve_cnt <= starve_cnt + CW'(1);
      end
    end
  end

  // Sticky error for beats nobody owns; only reset clears it.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rd_err <= 1'b0;
    end else if (stray) begin
      rd_err <= 1'b1;
    end
  end

endmodule
